// File: rtl/swap_pkg.sv
// Shared types and constants for the bit-swap cipher datapath.
// Used by both the encryptor and the decryptor.
package swap_pkg;

  localparam int DATA_W = 8;
  localparam int POS_W  = 3;

  // One key entry: two bit positions to exchange; pos1 sits in the low bits.
  typedef struct packed {
    logic [POS_W-1:0] pos2;
    logic [POS_W-1:0] pos1;
  } swap_pair_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that walks NUM_SWAPS pairs; never zero so NUM_SWAPS=1 still builds.
  function automatic int idx_width(input int num_swaps);
    return (num_swaps > 1) ? $clog2(num_swaps) : 1;
  endfunction

endpackage

// File: rtl/swap_decryptor_if.sv
// Valid/ready bundle between the decryptor and its producer/consumer.
// The slave modport is the decryptor's view.
interface swap_decryptor_if #(
  parameter int NUM_SWAPS = 4
);
  import swap_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             cipher;
  logic [NUM_SWAPS*2*POS_W-1:0]  key;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_W-1:0]             plain;
  logic                          busy;

  modport slave (
    input  in_valid, cipher, key, out_ready,
    output in_ready, out_valid, plain, busy
  );

  modport master (
    output in_valid, cipher, key, out_ready,
    input  in_ready, out_valid, plain, busy
  );

endinterface

// File: rtl/bit_swap.sv
// Combinational exchange of two bits of a byte; pos1 == pos2 leaves data untouched.
// Shared with the encryptor.
module bit_swap
  import swap_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [POS_W-1:0]  pos1_i,
  input  logic [POS_W-1:0]  pos2_i,
  output logic [DATA_W-1:0] data_o
);

  // NOTE: blocking assignments in combinational logic; the later writes
  // deliberately override the default copy, and every path assigns data_o first.
  always_comb begin
    data_o         = data_i;
    data_o[pos1_i] = data_i[pos2_i];
    data_o[pos2_i] = data_i[pos1_i];
  end

endmodule

// File: rtl/swap_decryptor.sv
// Undoes the swap-pair cipher one pair per clock, last pair first,
// behind valid/ready handshakes on both sides.
module swap_decryptor
  import swap_pkg::*;
#(
  parameter int NUM_SWAPS = 4
) (
  input  logic            clk,
  input  logic            rst,
  swap_decryptor_if.slave bus_if
);

  localparam int IDX_W = idx_width(NUM_SWAPS);

  state_t                      state_q, state_d;
  logic [DATA_W-1:0]           data_q, data_d;
  swap_pair_t [NUM_SWAPS-1:0]  key_q, key_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        out_valid_q;

  swap_pair_t                  cur_pair;
  logic [DATA_W-1:0]           swapped;

  assign cur_pair = key_q[idx_q];

  bit_swap u_bit_swap (
    .data_i (data_q),
    .pos1_i (cur_pair.pos1),
    .pos2_i (cur_pair.pos2),
    .data_o (swapped)
  );

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        if (bus_if.in_valid) begin
          data_d  = bus_if.cipher;
          key_d   = bus_if.key;
          idx_d   = IDX_W'(NUM_SWAPS - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        data_d = swapped;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (bus_if.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. The key
  // register is reset too, so a post-reset view of the datapath is fully defined.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      key_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      key_q       <= key_d;
      idx_q       <= idx_d;
      out_valid_q <= (state_d == DONE);
    end
  end

  // in_ready depends on state alone, keeping out_ready off any combinational path to it.
  assign bus_if.in_ready  = (state_q == IDLE);
  assign bus_if.busy      = (state_q != IDLE);
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.plain     = data_q;

endmodule

// File: tb/tb_swap_decryptor.sv
// Self-checking bench for swap_decryptor: directed scenarios plus randomized
// bytes/keys against a reference model of the swap-pair cipher.
module tb_swap_decryptor;

  localparam int NS = 4;
  localparam int KW = NS * 6;
  localparam logic [KW-1:0] KEY_A = 24'hB01187;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  swap_decryptor_if #(.NUM_SWAPS(NS)) bus ();

  swap_decryptor #(.NUM_SWAPS(NS)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: the encryptor swaps pairs 0..NS-1 in order, so decryption
  // undoes them from the last pair back to the first.
  function automatic logic [7:0] model(input logic [7:0] c, input logic [KW-1:0] k);
    logic [7:0] d;
    d = c;
    for (int i = NS - 1; i >= 0; i--) begin
      int   p1;
      int   p2;
      logic b;
      p1    = int'(k[i*6 +: 3]);
      p2    = int'(k[i*6 + 3 +: 3]);
      b     = d[p1];
      d[p1] = d[p2];
      d[p2] = b;
    end
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and return the cycle stamp of its acceptance edge.
  task automatic send_byte(input logic [7:0] c, input logic [KW-1:0] k, output int acc);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      step();
      n++;
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.cipher   = c;
    bus.key      = k;
    step();
    acc          = cyc;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; lat counts edges after the acceptance edge.
  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL out_timeout: out_valid=%b required 1", bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.plain} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_state: rdy/vld/busy/plain=%b/%b/%b/%h required 1/0/0/00",
               bus.in_ready, bus.out_valid, bus.busy, bus.plain);
    end
  endtask

  task automatic test_basic();
    int acc, lat;
    bus.out_ready = 1'b1;
    send_byte(8'hB1, KEY_A, acc);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_run_flags: busy=%b in_ready=%b required 1/0", bus.busy, bus.in_ready);
    end
    wait_out(lat);
    n_cmp++;
    if (lat !== NS) begin
      n_err++;
      $display("FAIL basic_latency: got %0d required %0d", lat, NS);
    end
    n_cmp++;
    if (bus.plain !== 8'h33 || bus.plain !== model(8'hB1, KEY_A)) begin
      n_err++;
      $display("FAIL basic_plain: got %h required 33 (model %h)", bus.plain, model(8'hB1, KEY_A));
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_one_cycle: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_identity();
    int acc, lat;
    logic [KW-1:0] k;
    k = {NS{6'b010_010}};
    send_byte(8'h5A, k, acc);
    wait_out(lat);
    n_cmp++;
    if (bus.plain !== 8'h5A) begin
      n_err++;
      $display("FAIL identity_plain: got %h required 5a", bus.plain);
    end
    step();
  endtask

  task automatic test_backpressure();
    int acc, lat;
    bus.out_ready = 1'b0;
    send_byte(8'hB1, KEY_A, acc);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.plain} !== {1'b1, 1'b0, 8'h33}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: vld/rdy/plain=%b/%b/%h required 1/0/33",
                 i, bus.out_valid, bus.in_ready, bus.plain);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_busy_ignore();
    int acc, lat, extra;
    bus.out_ready = 1'b1;
    send_byte(8'hB1, KEY_A, acc);
    bus.in_valid = 1'b1;
    bus.cipher   = 8'hFF;
    bus.key      = '0;
    wait_out(lat);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.plain !== 8'h33) begin
      n_err++;
      $display("FAIL ignore_plain: got %h required 33", bus.plain);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid === 1'b1) extra++;
    end
    n_cmp++;
    if (extra !== 0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_no_second: extra outputs=%0d busy=%b required 0/0", extra, bus.busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int acc, lat, seen;
    bus.out_ready = 1'b1;
    send_byte(8'hB1, KEY_A, acc);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.plain} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL midrun_reset: rdy/vld/busy/plain=%b/%b/%b/%h required 1/0/0/00",
               bus.in_ready, bus.out_valid, bus.busy, bus.plain);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.out_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL midrun_no_output: saw %0d outputs required 0", seen);
    end
    send_byte(8'hB1, KEY_A, acc);
    wait_out(lat);
    n_cmp++;
    if (bus.plain !== 8'h33) begin
      n_err++;
      $display("FAIL midrun_recover: got %h required 33", bus.plain);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int         acc[$];
    logic [7:0] exp[2];
    int         outs, n;
    bit         fire;
    exp[0] = model(8'hB1, KEY_A);
    exp[1] = model(8'h33, KEY_A);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.cipher    = 8'hB1;
    bus.key       = KEY_A;
    outs = 0;
    n    = 0;
    while (outs < 2 && n < 40) begin
      fire = bus.in_valid && bus.in_ready;
      step();
      n++;
      if (fire) begin
        acc.push_back(cyc);
        if (acc.size() == 1) bus.cipher = 8'h33;
        else bus.in_valid = 1'b0;
      end
      if (bus.out_valid === 1'b1) begin
        n_cmp++;
        if (bus.plain !== exp[outs]) begin
          n_err++;
          $display("FAIL b2b_plain[%0d]: got %h required %h", outs, bus.plain, exp[outs]);
        end
        outs++;
      end
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (outs !== 2 || acc.size() !== 2) begin
      n_err++;
      $display("FAIL b2b_count: outputs=%0d accepts=%0d required 2/2", outs, acc.size());
    end else begin
      n_cmp++;
      if (acc[1] - acc[0] !== NS + 2) begin
        n_err++;
        $display("FAIL b2b_spacing: got %0d required %0d", acc[1] - acc[0], NS + 2);
      end
    end
    n_cmp++;
    if (exp[0] !== 8'h33) begin
      n_err++;
      $display("FAIL b2b_first_ref: model gives %h required 33", exp[0]);
    end
    step();
  endtask

  task automatic test_random();
    int            acc, lat, stall;
    logic [7:0]    c, e;
    logic [KW-1:0] k;
    for (int t = 0; t < 25; t++) begin
      c = 8'($urandom);
      for (int i = 0; i < NS; i++) k[i*6 +: 6] = 6'($urandom);
      e     = model(c, k);
      stall = int'($urandom_range(0, 3));
      bus.out_ready = (stall == 0);
      send_byte(c, k, acc);
      bus.cipher = 8'($urandom);
      bus.key    = KW'({$urandom, $urandom});
      wait_out(lat);
      n_cmp++;
      if (lat !== NS || bus.plain !== e) begin
        n_err++;
        $display("FAIL rand[%0d]: plain=%h lat=%0d required %h/%0d (c=%h k=%h)",
                 t, bus.plain, lat, e, NS, c, k);
      end
      for (int s = 0; s < stall; s++) begin
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.plain !== e) begin
          n_err++;
          $display("FAIL rand_hold[%0d]: vld=%b plain=%h required 1/%h", t, bus.out_valid, bus.plain, e);
        end
      end
      bus.out_ready = 1'b1;
      step();
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.cipher    = '0;
    bus.key       = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_identity();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
